// File: rtl/uart_receiver.sv
// 8N1 UART receiver feeding a single-entry ready/valid holding register.
// Framing errors and overruns are reported as one-cycle pulses.
module uart_receiver #(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 115_200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       serial_in,
  output logic [7:0] data_out,
  output logic       data_out_valid,
  input  logic       data_out_ready,
  output logic       framing_error,
  output logic       overrun
);

  localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
  localparam int SAMPLE_TIME      = SYMBOL_EDGE_TIME / 2;
  localparam int CW               = $clog2(SYMBOL_EDGE_TIME);

  localparam logic [CW-1:0] EDGE_LAST   = CW'(SYMBOL_EDGE_TIME - 1);
  localparam logic [CW-1:0] SAMPLE_LAST = CW'(SAMPLE_TIME - 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] STOP  = 3'd3;
  localparam logic [2:0] BREAK = 3'd4;

  logic          rx_meta;
  logic          rx_s;
  logic [2:0]    state_q, state_d;
  logic [CW-1:0] counter_q, counter_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          byte_done_q, byte_done_d;
  logic          framing_error_q, framing_error_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          overrun_q, overrun_d;

  // Synchroniser resets to the idle line level so reset release never looks like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= serial_in;
      rx_s    <= rx_meta;
    end
  end

  always_comb begin
    state_d         = state_q;
    counter_d       = counter_q;
    bit_idx_d       = bit_idx_q;
    shift_d         = shift_q;
    byte_done_d     = 1'b0;
    framing_error_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d   = START;
          counter_d = '0;
        end
      end
      START: begin
        if (counter_q == SAMPLE_LAST) begin
          if (rx_s) begin
            state_d = IDLE;
          end else begin
            state_d   = DATA;
            counter_d = '0;
            bit_idx_d = 3'd0;
          end
        end else begin
          counter_d = counter_q + CW'(1);
        end
      end
      DATA: begin
        if (counter_q == EDGE_LAST) begin
          shift_d[bit_idx_q] = rx_s;
          counter_d          = '0;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          counter_d = counter_q + CW'(1);
        end
      end
      STOP: begin
        if (counter_q == EDGE_LAST) begin
          counter_d = '0;
          if (rx_s) begin
            state_d     = IDLE;
            byte_done_d = 1'b1;
          end else begin
            state_d         = BREAK;
            framing_error_d = 1'b1;
          end
        end else begin
          counter_d = counter_q + CW'(1);
        end
      end
      // A held-low line must return high before another start bit is considered.
      BREAK: begin
        if (rx_s) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d   = IDLE;
        counter_d = '0;
      end
    endcase
  end

  // Completed byte is offered to the holding register one cycle after the stop sample.
  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;
    if (byte_done_q) begin
      if (!valid_q || data_out_ready) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && data_out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      counter_q       <= '0;
      bit_idx_q       <= 3'd0;
      shift_q         <= 8'h00;
      byte_done_q     <= 1'b0;
      framing_error_q <= 1'b0;
      data_q          <= 8'h00;
      valid_q         <= 1'b0;
      overrun_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      counter_q       <= counter_d;
      bit_idx_q       <= bit_idx_d;
      shift_q         <= shift_d;
      byte_done_q     <= byte_done_d;
      framing_error_q <= framing_error_d;
      data_q          <= data_d;
      valid_q         <= valid_d;
      overrun_q       <= overrun_d;
    end
  end

  assign data_out       = data_q;
  assign data_out_valid = valid_q;
  assign framing_error  = framing_error_q;
  assign overrun        = overrun_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at 10 clocks per bit.
module tb_uart_receiver;

  logic       clk = 1'b0;
  logic       rst;
  logic       serial_in;
  logic [7:0] data_out;
  logic       data_out_valid;
  logic       data_out_ready;
  logic       framing_error;
  logic       overrun;

  uart_receiver #(
    .CLOCK_FREQ(1_000_000),
    .BAUD_RATE (100_000)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .serial_in     (serial_in),
    .data_out      (data_out),
    .data_out_valid(data_out_valid),
    .data_out_ready(data_out_ready),
    .framing_error (framing_error),
    .overrun       (overrun)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor, sampled on the falling edge.
  int unsigned n_vcyc = 0, n_rise = 0, n_fe = 0, n_ov = 0, n_xfer = 0, rise_cyc = 0;
  logic [7:0]  last_xfer = 8'h00;
  logic        v_prev = 1'b0;

  always @(negedge clk) begin
    if (data_out_valid) n_vcyc <= n_vcyc + 1;
    if (data_out_valid && !v_prev) begin
      n_rise   <= n_rise + 1;
      rise_cyc <= cyc;
    end
    v_prev <= data_out_valid;
    if (framing_error) n_fe <= n_fe + 1;
    if (overrun) n_ov <= n_ov + 1;
    if (data_out_valid && data_out_ready) begin
      n_xfer    <= n_xfer + 1;
      last_xfer <= data_out;
    end
  end

  int unsigned n_cmp = 0, n_fail = 0;
  int unsigned b_vcyc, b_rise, b_fe, b_ov, b_xfer;
  int unsigned t0;
  int          lat;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic snap();
    b_vcyc = n_vcyc;
    b_rise = n_rise;
    b_fe   = n_fe;
    b_ov   = n_ov;
    b_xfer = n_xfer;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    serial_in = 1'b0;
    tick(10);
    for (int i = 0; i < 8; i++) begin
      serial_in = b[i];
      tick(10);
    end
    serial_in = stop_bit;
    tick(10);
  endtask

  initial begin
    rst            = 1'b1;
    serial_in      = 1'b1;
    data_out_ready = 1'b0;

    // 1: reset held for 10 cycles, then released
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("reset_outputs", 32'({data_out, data_out_valid, framing_error, overrun}), 32'h0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick(5);
    check("post_reset_outputs", 32'({data_out, data_out_valid, framing_error, overrun}), 32'h0);

    // 2: 0xA5 with ready=1
    data_out_ready = 1'b1;
    snap();
    t0 = cyc + 1;
    send_frame(8'hA5, 1'b1);
    tick(5);
    lat = int'(rise_cyc) - int'(t0);
    check("a5_rise_count", n_rise - b_rise, 32'd1);
    check("a5_latency_in_window", 32'(lat >= 97 && lat <= 99), 32'd1);
    check("a5_valid_cycles", n_vcyc - b_vcyc, 32'd1);
    check("a5_xfer_count", n_xfer - b_xfer, 32'd1);
    check("a5_data", 32'(last_xfer), 32'hA5);
    check("a5_no_errors", (n_fe - b_fe) + (n_ov - b_ov), 32'd0);

    // 3: 0x3C then 0x81 back-to-back with ready=0
    data_out_ready = 1'b0;
    snap();
    send_frame(8'h3C, 1'b1);
    send_frame(8'h81, 1'b1);
    tick(3);
    check("ovr_pulse_count", n_ov - b_ov, 32'd1);
    check("ovr_data_held", 32'(data_out), 32'h3C);
    check("ovr_valid_held", 32'(data_out_valid), 32'd1);
    check("ovr_no_fe", n_fe - b_fe, 32'd0);
    snap();
    data_out_ready = 1'b1;
    tick(1);
    check("ovr_drain_valid", 32'(data_out_valid), 32'd0);
    check("ovr_drain_data", 32'(last_xfer), 32'h3C);
    tick(3);
    check("ovr_single_xfer", n_xfer - b_xfer, 32'd1);

    // 4: 3-cycle glitch, then 0x55
    data_out_ready = 1'b0;
    snap();
    serial_in = 1'b0;
    tick(3);
    serial_in = 1'b1;
    tick(30);
    check("glitch_no_valid", (n_rise - b_rise) + 32'(data_out_valid), 32'd0);
    check("glitch_no_fe", n_fe - b_fe, 32'd0);
    send_frame(8'h55, 1'b1);
    tick(2);
    check("f55_valid", 32'(data_out_valid), 32'd1);
    check("f55_data", 32'(data_out), 32'h55);
    data_out_ready = 1'b1;
    tick(1);
    data_out_ready = 1'b0;
    tick(1);
    check("f55_drained", 32'(data_out_valid), 32'd0);

    // 5: bad stop bit, line held low 30 more cycles, then 0x12
    snap();
    send_frame(8'hFF, 1'b0);
    tick(30);
    serial_in = 1'b1;
    tick(5);
    check("brk_fe_count", n_fe - b_fe, 32'd1);
    check("brk_no_valid", (n_rise - b_rise) + 32'(data_out_valid), 32'd0);
    check("brk_no_ovr", n_ov - b_ov, 32'd0);
    send_frame(8'h12, 1'b1);
    tick(2);
    check("f12_valid", 32'(data_out_valid), 32'd1);
    check("f12_data", 32'(data_out), 32'h12);

    // 6: reset during bit 4 of 0xF0 while 0x12 is still held
    serial_in = 1'b0;
    tick(50);
    serial_in = 1'b1;
    tick(4);
    rst = 1'b1;
    #1;
    check("rst_async_outputs", 32'({data_out, data_out_valid, framing_error, overrun}), 32'h0);
    tick(2);
    rst = 1'b0;
    snap();
    tick(60);
    check("rst_rest_no_valid", (n_rise - b_rise) + 32'(data_out_valid), 32'd0);
    check("rst_rest_no_errors", (n_fe - b_fe) + (n_ov - b_ov), 32'd0);
    send_frame(8'h7E, 1'b1);
    tick(2);
    check("f7e_valid", 32'(data_out_valid), 32'd1);
    check("f7e_data", 32'(data_out), 32'h7E);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
